// File: rtl/ssd_pkg.sv
// ----------------------------------------------------------------------------
// ssd_pkg
// Shared types and constants for the seven-segment scan controller.
//   seg_t      : segment vector {a,b,c,d,e,f,g}, active-low
//   SEG_OFF    : all segments dark
//   hex_to_seg : nibble to active-low segment pattern (0-9, A-F)
// ----------------------------------------------------------------------------
package ssd_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_OFF = 7'b1111111;

    // Hex font for the board display. Lower-case b and d are used so that
    // they cannot be confused with 8 and 0.
    function automatic seg_t hex_to_seg(input logic [3:0] nib);
        seg_t seg;
        case (nib)
            4'h0:    seg = 7'b0000001;
            4'h1:    seg = 7'b1001111;
            4'h2:    seg = 7'b0010010;
            4'h3:    seg = 7'b0000110;
            4'h4:    seg = 7'b1001100;
            4'h5:    seg = 7'b0100100;
            4'h6:    seg = 7'b0100000;
            4'h7:    seg = 7'b0001111;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0000100;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b1100000;
            4'hC:    seg = 7'b0110001;
            4'hD:    seg = 7'b1000010;
            4'hE:    seg = 7'b0110000;
            default: seg = 7'b0111000;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/ssd_scan_controller_if.sv
// ----------------------------------------------------------------------------
// ssd_scan_controller_if
// Control bundle from the score/status logic to the display scanner.
//   value      : hex nibbles, nibble i belongs to digit i (digit 0 rightmost)
//   dp_in      : decimal point request per digit, active-high
//   digit_en   : per-digit enable, active-high
//   load       : single-cycle strobe that captures value/dp_in
//   lz_blank   : leading-zero blanking enable (level)
//   brightness : PWM duty, 0 = off, all-ones = full on
// master = producer (game logic / bench), slave = ssd_scan_controller.
// ----------------------------------------------------------------------------
interface ssd_scan_controller_if #(
    parameter int NUM_DIGITS = 8,
    parameter int BRIGHT_W   = 4
);

    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic                    load;
    logic                    lz_blank;
    logic [BRIGHT_W-1:0]     brightness;

    modport master (
        output value, dp_in, digit_en, load, lz_blank, brightness
    );

    modport slave (
        input value, dp_in, digit_en, load, lz_blank, brightness
    );

endinterface

// File: rtl/ssd_hex_decode.sv
// ----------------------------------------------------------------------------
// ssd_hex_decode
// Combinational nibble to seven-segment decoder.
//   nibble_i : hex digit to show
//   seg_o    : active-low segments {a,b,c,d,e,f,g}
// ----------------------------------------------------------------------------
module ssd_hex_decode
    import ssd_pkg::*;
(
    input  logic [3:0] nibble_i,
    output seg_t       seg_o
);

    assign seg_o = hex_to_seg(nibble_i);

endmodule

// File: rtl/ssd_scan_controller.sv
// ----------------------------------------------------------------------------
// ssd_scan_controller
// Multiplexed seven-segment driver with shadow-loaded value, per-digit enable,
// leading-zero blanking and PWM brightness.
//   board_clk  : system clock
//   Reset      : asynchronous, active-high reset
//   bus        : control bundle (value, dp_in, digit_en, load, lz_blank,
//                brightness), slave side
//   anodes     : active-low anode drives, registered
//   cathodes   : active-low segments {a..g}, registered
//   dp         : active-low decimal point, registered
//   digit_idx  : index of the digit currently being scanned
//   scan_tick  : pulse in the last cycle of each digit slot
// ----------------------------------------------------------------------------
module ssd_scan_controller
    import ssd_pkg::*;
#(
    parameter  int NUM_DIGITS    = 8,
    parameter  int SCAN_DIV_LOG2 = 18,
    parameter  int BRIGHT_W      = 4,
    localparam int IDX_W         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                  board_clk,
    input  logic                  Reset,
    ssd_scan_controller_if.slave  bus,
    output logic [NUM_DIGITS-1:0] anodes,
    output seg_t                  cathodes,
    output logic                  dp,
    output logic [IDX_W-1:0]      digit_idx,
    output logic                  scan_tick
);

    logic [SCAN_DIV_LOG2-1:0] prescaler_q, prescaler_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0]  shadow_val_q, shadow_val_d;
    logic [NUM_DIGITS-1:0]    shadow_dp_q, shadow_dp_d;
    logic [NUM_DIGITS-1:0]    anodes_q, anodes_d;
    seg_t                     cathodes_q, cathodes_d;
    logic                     dp_q, dp_d;

    logic [NUM_DIGITS-1:0]    blank_vec;
    logic [3:0]               cur_nib;
    seg_t                     cur_seg;
    logic                     cur_blank;
    logic                     lit;
    logic                     drive;

    // The slot ends when the prescaler is about to wrap.
    assign scan_tick = &prescaler_q;

    // Free-running prescaler, digit index that advances after each tick, and
    // the shadow copy of the displayed data. The shadow only moves on load, so
    // the scan always shows one consistent snapshot. A load that lands on a
    // tick edge is already in the shadow when the next slot is evaluated.
    always_comb begin
        prescaler_d  = prescaler_q + SCAN_DIV_LOG2'(1);
        idx_d        = idx_q;
        shadow_val_d = shadow_val_q;
        shadow_dp_d  = shadow_dp_q;
        if (scan_tick) begin
            if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end
        if (bus.load) begin
            shadow_val_d = bus.value;
            shadow_dp_d  = bus.dp_in;
        end
    end

    // Leading-zero blanking: walk from the most significant digit downwards
    // and keep blanking while every nibble seen so far is zero. Digit 0 is
    // never blanked so an all-zero value still shows a single 0.
    always_comb begin
        logic all_zero;
        blank_vec = '0;
        all_zero  = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            all_zero = all_zero & (shadow_val_q[4*i +: 4] == 4'h0);
            if (i > 0) begin
                blank_vec[i] = bus.lz_blank & all_zero;
            end
        end
    end

    assign cur_nib   = shadow_val_q[{idx_q, 2'b00} +: 4];
    assign cur_blank = blank_vec[idx_q];

    ssd_hex_decode u_hex_decode (
        .nibble_i (cur_nib),
        .seg_o    (cur_seg)
    );

    // PWM compares the top bits of the prescaler with the duty value; the
    // all-ones duty is forced on so full brightness has no dark cycle.
    assign lit   = (prescaler_q[SCAN_DIV_LOG2-1 -: BRIGHT_W] < bus.brightness)
                 | (&bus.brightness);
    assign drive = bus.digit_en[idx_q] & ~cur_blank & lit;

    // Next pin state from the current scan position. At most the selected
    // anode is pulled low; anode and cathodes are computed from the same
    // index so they switch together on a digit change.
    always_comb begin
        anodes_d   = '1;
        cathodes_d = cur_blank ? SEG_OFF : cur_seg;
        dp_d       = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (drive && (idx_q == IDX_W'(i))) begin
                anodes_d[i] = 1'b0;
            end
        end
        if (drive) begin
            dp_d = ~shadow_dp_q[idx_q];
        end
    end

    // All state, including the pin registers, clears asynchronously so the
    // display goes dark the moment Reset rises.
    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            prescaler_q  <= '0;
            idx_q        <= '0;
            shadow_val_q <= '0;
            shadow_dp_q  <= '0;
            anodes_q     <= '1;
            cathodes_q   <= SEG_OFF;
            dp_q         <= 1'b1;
        end else begin
            prescaler_q  <= prescaler_d;
            idx_q        <= idx_d;
            shadow_val_q <= shadow_val_d;
            shadow_dp_q  <= shadow_dp_d;
            anodes_q     <= anodes_d;
            cathodes_q   <= cathodes_d;
            dp_q         <= dp_d;
        end
    end

    assign anodes    = anodes_q;
    assign cathodes  = cathodes_q;
    assign dp        = dp_q;
    assign digit_idx = idx_q;

endmodule

// File: tb/tb_ssd_scan_controller.sv
// ----------------------------------------------------------------------------
// tb_ssd_scan_controller
// Directed bench for ssd_scan_controller with 4 digits, 16-cycle slots and a
// 2-bit brightness. Whole frames are captured per table entry and compared
// against hand-computed anode duty, segment and dp values.
// ----------------------------------------------------------------------------
module tb_ssd_scan_controller;

    localparam int ND = 4;
    localparam int SD = 4;
    localparam int BW = 2;

    logic          board_clk;
    logic          Reset;
    logic [ND-1:0] anodes;
    logic [6:0]    cathodes;
    logic          dp;
    logic [1:0]    digit_idx;
    logic          scan_tick;

    int compared;
    int mismatched;

    ssd_scan_controller_if #(.NUM_DIGITS(ND), .BRIGHT_W(BW)) bus ();

    ssd_scan_controller #(
        .NUM_DIGITS    (ND),
        .SCAN_DIV_LOG2 (SD),
        .BRIGHT_W      (BW)
    ) dut (
        .board_clk (board_clk),
        .Reset     (Reset),
        .bus       (bus),
        .anodes    (anodes),
        .cathodes  (cathodes),
        .dp        (dp),
        .digit_idx (digit_idx),
        .scan_tick (scan_tick)
    );

    // 100 MHz board clock; outputs are sampled on the falling edge.
    initial begin
        board_clk = 1'b0;
        forever #5 board_clk = ~board_clk;
    end

    // One table entry describes the inputs for a frame and what each digit
    // slot must show. Packed arrays are ordered {digit3, digit2, digit1, digit0}.
    typedef struct {
        logic [15:0]     value;
        logic [3:0]      dpIn;
        logic [3:0]      en;
        logic            lz;
        logic [1:0]      br;
        logic            doLoad;
        logic [3:0][4:0] expLow;
        logic [3:0][6:0] expCath;
        logic [3:0]      cathMask;
        logic [3:0]      expDp;
    } vec_t;

    vec_t vecs [13];

    // Compare one value and report it.
    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive the control bundle for one table entry and pulse load if asked.
    task automatic applyStimulus(input int r);
        @(negedge board_clk);
        bus.value      = vecs[r].value;
        bus.dp_in      = vecs[r].dpIn;
        bus.digit_en   = vecs[r].en;
        bus.lz_blank   = vecs[r].lz;
        bus.brightness = vecs[r].br;
        if (vecs[r].doLoad) begin
            bus.load = 1'b1;
            @(negedge board_clk);
            bus.load = 1'b0;
        end
    endtask

    // Wait for the falling edge on which scan_tick is high with the given
    // index, within a bounded number of cycles.
    task automatic waitTickIdx(input logic [1:0] k, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge board_clk);
            if (scan_tick && digit_idx == k) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL wait_tick_idx%0d: no tick within 200 cycles", k);
        end
    endtask

    // Capture one full frame aligned to digit 0 and compare it to entry r.
    // Sample j reflects prescaler j%16 of digit j/16.
    task automatic measureFrame(input int r);
        int   lowCnt [ND];
        logic [6:0] cathAt [ND];
        logic dpAt [ND];
        int   slotErr, tickErr, idxErr, d, p;
        bit   ok;
        slotErr = 0;
        tickErr = 0;
        idxErr  = 0;
        for (int i = 0; i < ND; i++) begin
            lowCnt[i] = 0;
            cathAt[i] = 7'h00;
            dpAt[i]   = 1'b0;
        end
        waitTickIdx(2'd3, ok);
        if (!ok) return;
        @(negedge board_clk);
        for (int j = 0; j < 16 * ND; j++) begin
            @(negedge board_clk);
            d = j / 16;
            p = j % 16;
            for (int i = 0; i < ND; i++) begin
                if (!anodes[i]) begin
                    lowCnt[i]++;
                    if (i != d) slotErr++;
                end
            end
            if ($countones(~anodes) > 1) slotErr++;
            if (p == 0) begin
                cathAt[d] = cathodes;
                dpAt[d]   = dp;
            end
            if (scan_tick != (p == 14)) tickErr++;
            if (digit_idx != 2'(((j + 1) / 16) % ND)) idxErr++;
        end
        for (int i = 0; i < ND; i++) begin
            checkOutput($sformatf("r%0d_low_d%0d", r, i), lowCnt[i],
                        32'(vecs[r].expLow[i]));
            checkOutput($sformatf("r%0d_dp_d%0d", r, i), dpAt[i],
                        vecs[r].expDp[i]);
            if (vecs[r].cathMask[i]) begin
                checkOutput($sformatf("r%0d_cath_d%0d", r, i), cathAt[i],
                            vecs[r].expCath[i]);
            end
        end
        checkOutput($sformatf("r%0d_slot_errors", r), slotErr, 0);
        checkOutput($sformatf("r%0d_tick_errors", r), tickErr, 0);
        checkOutput($sformatf("r%0d_idx_errors", r), idxErr, 0);
    endtask

    initial begin
        bit ok;
        compared   = 0;
        mismatched = 0;

        //             value     dpIn     en       lz    br    ld
        vecs[0]  = '{16'h1234, 4'b0000, 4'b1111, 1'b0, 2'd3, 1'b1,
                     {5'd16, 5'd16, 5'd16, 5'd16},
                     {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100},
                     4'b1111, 4'b1111};
        vecs[1]  = '{16'h0050, 4'b0000, 4'b1111, 1'b1, 2'd3, 1'b1,
                     {5'd0, 5'd0, 5'd16, 5'd16},
                     {7'b1111111, 7'b1111111, 7'b0100100, 7'b0000001},
                     4'b1111, 4'b1111};
        vecs[2]  = '{16'h0000, 4'b0000, 4'b1111, 1'b1, 2'd3, 1'b1,
                     {5'd0, 5'd0, 5'd0, 5'd16},
                     {7'b1111111, 7'b1111111, 7'b1111111, 7'b0000001},
                     4'b1111, 4'b1111};
        vecs[3]  = '{16'h1234, 4'b0000, 4'b1111, 1'b0, 2'd1, 1'b1,
                     {5'd4, 5'd4, 5'd4, 5'd4},
                     {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100},
                     4'b1111, 4'b1111};
        vecs[4]  = '{16'h1234, 4'b0000, 4'b1111, 1'b0, 2'd2, 1'b0,
                     {5'd8, 5'd8, 5'd8, 5'd8},
                     {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100},
                     4'b1111, 4'b1111};
        vecs[5]  = '{16'h1234, 4'b0000, 4'b1111, 1'b0, 2'd0, 1'b0,
                     {5'd0, 5'd0, 5'd0, 5'd0},
                     {7'b0, 7'b0, 7'b0, 7'b0},
                     4'b0000, 4'b1111};
        vecs[6]  = '{16'h1234, 4'b0010, 4'b1010, 1'b0, 2'd3, 1'b1,
                     {5'd16, 5'd0, 5'd16, 5'd0},
                     {7'b1001111, 7'b0, 7'b0000110, 7'b0},
                     4'b1010, 4'b1101};
        vecs[7]  = '{16'hCDEB, 4'b0000, 4'b1111, 1'b0, 2'd3, 1'b1,
                     {5'd16, 5'd16, 5'd16, 5'd16},
                     {7'b0110001, 7'b1000010, 7'b0110000, 7'b1100000},
                     4'b1111, 4'b1111};
        vecs[8]  = '{16'h6789, 4'b0000, 4'b1111, 1'b0, 2'd3, 1'b1,
                     {5'd16, 5'd16, 5'd16, 5'd16},
                     {7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100},
                     4'b1111, 4'b1111};
        vecs[9]  = '{16'hA0F0, 4'b0101, 4'b1111, 1'b1, 2'd3, 1'b1,
                     {5'd16, 5'd16, 5'd16, 5'd16},
                     {7'b0001000, 7'b0000001, 7'b0111000, 7'b0000001},
                     4'b1111, 4'b1010};
        vecs[10] = vecs[0];
        vecs[11] = '{16'hFFFF, 4'b0000, 4'b1111, 1'b0, 2'd3, 1'b0,
                     {5'd16, 5'd16, 5'd16, 5'd16},
                     {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100},
                     4'b1111, 4'b1111};
        vecs[12] = '{16'hFFFF, 4'b0000, 4'b1111, 1'b0, 2'd3, 1'b0,
                     {5'd16, 5'd16, 5'd16, 5'd16},
                     {7'b0111000, 7'b0111000, 7'b0111000, 7'b0111000},
                     4'b1111, 4'b1111};

        // Power-on reset.
        Reset          = 1'b1;
        bus.value      = 16'h0000;
        bus.dp_in      = 4'b0000;
        bus.digit_en   = 4'b1111;
        bus.load       = 1'b0;
        bus.lz_blank   = 1'b0;
        bus.brightness = 2'd3;
        #1;
        checkOutput("rst_anodes", anodes, 4'b1111);
        checkOutput("rst_cathodes", cathodes, 7'b1111111);
        checkOutput("rst_dp", dp, 1'b1);
        checkOutput("rst_idx", digit_idx, 2'd0);
        checkOutput("rst_tick", scan_tick, 1'b0);
        @(negedge board_clk);
        @(negedge board_clk);
        Reset = 1'b0;
        @(negedge board_clk);
        checkOutput("rel_anodes", anodes, 4'b1110);
        checkOutput("rel_cathodes", cathodes, 7'b0000001);

        // Table-driven frames; entry 11 changes value without load.
        for (int r = 0; r < 12; r++) begin
            applyStimulus(r);
            measureFrame(r);
        end

        // Load coincident with the digit-2 tick: the rest of digit 2 keeps
        // the old data, digit 3 onward shows the new data.
        waitTickIdx(2'd2, ok);
        if (ok) begin
            bus.load = 1'b1;
            @(negedge board_clk);
            bus.load = 1'b0;
            checkOutput("tick_load_old_anodes", anodes, 4'b1011);
            checkOutput("tick_load_old_cath", cathodes, 7'b0010010);
            @(negedge board_clk);
            checkOutput("tick_load_new_anodes", anodes, 4'b0111);
            checkOutput("tick_load_new_cath", cathodes, 7'b0111000);
        end
        applyStimulus(12);
        measureFrame(12);

        // Reset in the middle of a slot.
        applyStimulus(0);
        waitTickIdx(2'd0, ok);
        repeat (5) @(negedge board_clk);
        Reset = 1'b1;
        #1;
        checkOutput("mid_rst_anodes", anodes, 4'b1111);
        checkOutput("mid_rst_cathodes", cathodes, 7'b1111111);
        checkOutput("mid_rst_dp", dp, 1'b1);
        checkOutput("mid_rst_idx", digit_idx, 2'd0);
        checkOutput("mid_rst_tick", scan_tick, 1'b0);
        @(negedge board_clk);
        @(negedge board_clk);
        checkOutput("mid_rst_hold_anodes", anodes, 4'b1111);
        Reset = 1'b0;
        @(negedge board_clk);
        checkOutput("mid_rel_anodes", anodes, 4'b1110);
        checkOutput("mid_rel_cathodes", cathodes, 7'b0000001);
        checkOutput("mid_rel_idx", digit_idx, 2'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ssd_scan_controller.md
Name: ssd_scan_controller

Overview:
Parametrised multiplexed seven-segment display driver. It replaces the hard-wired 4-digit scan and hex decode in the game top level. It supports N digits and a programmable scan rate, and adds four features:
- a tear-free shadow load of the displayed value;
- per-digit enable;
- leading-zero blanking;
- PWM brightness control.

It sits between the score/status logic and the board anode/cathode pins.

Parameters:
- NUM_DIGITS, 8: number of digits/anodes driven (1..16).
- SCAN_DIV_LOG2, 18: log2 of board_clk cycles per digit slot (100 MHz / 2^18 gives about 381 Hz per digit).
- BRIGHT_W, 4: brightness control width; must be ≤ SCAN_DIV_LOG2.

Ports:
- board_clk  in  1  system clock, 100 MHz.
- Reset  in  1  asynchronous, active-high reset.
- value  in  4*NUM_DIGITS  hex nibbles; nibble i drives digit i (digit 0 is least significant/rightmost).
- dp_in  in  NUM_DIGITS  decimal point request per digit, active-high.
- digit_en  in  NUM_DIGITS  per-digit enable, active-high.
- load  in  1  single-cycle strobe; captures value/dp_in into the shadow registers.
- lz_blank  in  1  enables leading-zero blanking (level).
- brightness  in  BRIGHT_W  duty control; 0 = off, all-ones = full on.
- anodes  out  NUM_DIGITS  anode drives, active-low, registered.
- cathodes  out  7  segments {a,b,c,d,e,f,g}, active-low, registered.
- dp  out  1  decimal point, active-low, registered.
- digit_idx  out  $clog2(NUM_DIGITS) (min 1)  index of the digit currently scanned.
- scan_tick  out  1  one-cycle pulse in the last cycle of each digit slot.

Behaviour:
- Clock and reset: board_clk with Reset, asynchronous, active-high. All state resets asynchronously.
- Reset values:
  - anodes = all 1s; cathodes = 7'b1111111; dp = 1;
  - digit_idx = 0; scan_tick = 0;
  - prescaler = 0; shadow value/dp = 0.
- Reset mid-scan: forces the above on the next evaluation; no partial slot completes.
- Prescaler:
  - SCAN_DIV_LOG2-bit free-running counter, wraps 2^SCAN_DIV_LOG2-1 → 0.
  - scan_tick = 1 exactly when prescaler = all ones.
- Digit index:
  - Increments on the clock edge following scan_tick.
  - Wraps NUM_DIGITS-1 → 0, including for non-power-of-two NUM_DIGITS.
- Shadow load:
  - load=1 at edge t: shadow updated at t.
  - Effect visible on the pins after the next edge (2-cycle latency from the load strobe).
  - Without load, the input value is ignored, so changes to value never tear a scan frame.
- Decode: shadow nibble at digit_idx → cathodes.
  - 0..9 = 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001111, 0000000, 0000100.
  - A..F = 0001000, 1100000, 0110001, 1000010, 0110000, 0111000.
- Leading-zero blanking:
  - Applies when lz_blank=1.
  - Digit i (i>0) is blanked if shadow nibbles NUM_DIGITS-1 down to i are all zero.
  - Digit 0 is never blanked, so value 0 shows a single "0".
  - A blanked digit gives cathodes = 1111111 and anode off; its dp is suppressed too.
- Enable: digit_en[i]=0 keeps anode i high for its whole slot. The slot still elapses and the scan period is unchanged.
- PWM lit condition: the current anode is driven low when digit enabled AND not blanked AND lit.
  - lit = (prescaler[SCAN_DIV_LOG2-1 -: BRIGHT_W] < brightness), or brightness = all ones.
  - brightness = 0 keeps all anodes high.
- Output timing: outputs are registered and reflect the prescaler/digit_idx state of the previous cycle.
  - Exactly one anode, or none, is low in any cycle.
  - On a digit change, the new anode and new cathodes switch on the same edge.
- dp: dp = ~shadow_dp[digit_idx] under the same lit/enable/blank conditions; otherwise 1.
- Simultaneous load and scan_tick: the new shadow data applies to the slot that begins after the tick.

Decomposition:
- Package ssd_pkg holds:
  - the SEG_OFF = 7'b1111111 constant;
  - a 16-entry hex-to-segment table/function;
  - the typedef seg_t (logic [6:0]).
- One sub-module, ssd_hex_decode: combinational nibble → seg_t using ssd_pkg.
- The top holds the prescaler, index counter, shadow registers, blanking/PWM logic and output registers.

Test Plan:
Bench parameters: NUM_DIGITS=4, SCAN_DIV_LOG2=4, BRIGHT_W=2.
- Reset: assert Reset mid-slot → anodes=4'b1111, cathodes=7'b1111111, dp=1, digit_idx=0 asynchronously. Release → digit 0 anode low by cycle 2.
- Scan order: brightness=3, digit_en=4'b1111, load value=16'h1234 → anodes cycle 1110, 1101, 1011, 0111, each for exactly 16 cycles. Cathodes are 1001100, 0000110, 0010010, 1001111 respectively. scan_tick pulses every 16 cycles.
- Blanking:
  - value=16'h0050 with lz_blank=1 → digits 3 and 2 have anode high; digits 1 and 0 show 5 and 0.
  - value=16'h0000 → only digit 0 is lit, showing 0000001.
- Shadow and tear-free load:
  - Change value to 16'hFFFF without load → display unchanged.
  - Pulse load during the digit-2 slot, coincident with scan_tick → the new data appears from the next slot onward, all digits 0111000.
- Brightness:
  - brightness=1 → each anode is low for 4 of 16 cycles.
  - brightness=2 → low for 8 of 16 cycles.
  - brightness=0 → anodes stay 1111 for the whole frame.
- Enable and dp: digit_en=4'b1010, dp_in=4'b0010 → digits 0 and 2 are never lit; digit 1 shows dp=0; digit 3 shows dp=1. Frame length stays 64 cycles.
